// File: rtl/clock_timer_multi_if.sv
// Register/strobe bus of the multi-channel clock timer.
// The master drives the strobes and write data; the slave is the timer itself.
interface clock_timer_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned NIBBLES  = 2
);
  localparam int unsigned SelW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic                clk_en;
  logic                run;
  logic                timer_reset;
  logic                mask_we;
  logic [CHANNELS-1:0] mask_wdata;
  logic [CHANNELS-1:0] mask;
  logic                factor_re;
  logic [CHANNELS-1:0] factor;
  logic                interrupt;
  logic                data_re;
  logic [SelW-1:0]     data_sel;
  logic [3:0]          data_out;

  modport master (
    output clk_en, run, timer_reset, mask_we, mask_wdata, factor_re, data_re, data_sel,
    input  mask, factor, interrupt, data_out
  );

  modport slave (
    input  clk_en, run, timer_reset, mask_we, mask_wdata, factor_re, data_re, data_sel,
    output mask, factor, interrupt, data_out
  );
endinterface

// File: rtl/clock_timer_multi.sv
// Free-running prescaler with sticky per-channel tap interrupts, a mask register and a
// nibble-wide read window with snapshot for tear-free multi-nibble reads.
module clock_timer_multi #(
  parameter int unsigned         COUNTER_WIDTH = 15,
  parameter int unsigned         CHANNELS      = 4,
  parameter logic [CHANNELS*8-1:0] TAPS        = {8'd14, 8'd13, 8'd11, 8'd9},
  parameter int unsigned         DATA_LSB      = 7,
  parameter int unsigned         NIBBLES       = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  clock_timer_multi_if.slave  bus
);

  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0] snapshot_q, snapshot_d;
  logic [CHANNELS-1:0]      factor_q, factor_d;
  logic [CHANNELS-1:0]      mask_q, mask_d;
  logic [CHANNELS-1:0]      factor_set;
  logic                     advance;

  // A cleared counter never counts as advancing, so timer_reset also suppresses sets.
  assign advance = bus.clk_en & bus.run & ~bus.timer_reset;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_tap
    localparam int unsigned Tap = 32'(TAPS[i*8 +: 8]);
    localparam logic [COUNTER_WIDTH-1:0] TapOnes =
        COUNTER_WIDTH'((64'd1 << (Tap + 1)) - 64'd1);

    if (Tap >= COUNTER_WIDTH) begin : g_bad_tap
      $error("clock_timer_multi: TAPS entry exceeds counter width");
    end

    // Low bits all ones while advancing == falling edge of the tap bit.
    assign factor_set[i] = advance & ((counter_q & TapOnes) == TapOnes);
  end

  if (DATA_LSB + 4 * NIBBLES > COUNTER_WIDTH) begin : g_bad_window
    $error("clock_timer_multi: read windows exceed counter width");
  end

  always_comb begin
    counter_d  = counter_q;
    snapshot_d = snapshot_q;
    mask_d     = mask_q;
    if (bus.timer_reset) begin
      counter_d = '0;
    end else if (bus.clk_en && bus.run) begin
      counter_d = counter_q + COUNTER_WIDTH'(1);
    end
    // A set coinciding with a read survives; everything else is cleared.
    factor_d = bus.factor_re ? factor_set : (factor_q | factor_set);
    if (bus.mask_we) begin
      mask_d = bus.mask_wdata;
    end
    if (bus.data_re && (bus.data_sel == '0)) begin
      snapshot_d = counter_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q  <= '0;
      snapshot_q <= '0;
      factor_q   <= '0;
      mask_q     <= '0;
    end else begin
      counter_q  <= counter_d;
      snapshot_q <= snapshot_d;
      factor_q   <= factor_d;
      mask_q     <= mask_d;
    end
  end

  // Window 0 reads live; higher windows read the copy taken by the last window-0 read.
  always_comb begin
    bus.data_out = 4'h0;
    if (bus.data_re && (32'(bus.data_sel) < NIBBLES)) begin
      if (bus.data_sel == '0) begin
        bus.data_out = 4'(counter_q >> DATA_LSB);
      end else begin
        bus.data_out = 4'(snapshot_q >> (DATA_LSB + 4 * 32'(bus.data_sel)));
      end
    end
  end

  assign bus.factor    = factor_q;
  assign bus.mask      = mask_q;
  assign bus.interrupt = |(factor_q & mask_q);

endmodule

// File: tb/tb_clock_timer_multi.sv
// Randomised bench for clock_timer_multi: a tick-count reference model feeds a scoreboard
// queue that a negedge monitor drains against the DUT outputs.
module tb_clock_timer_multi;
  localparam int unsigned Ch  = 4;
  localparam int unsigned Nib = 2;
  localparam int unsigned Cw  = 15;
  localparam int unsigned Lsb = 7;
  localparam int          Taps [Ch] = '{9, 11, 13, 14};

  logic clk = 1'b1;
  logic reset_n;

  clock_timer_multi_if #(.CHANNELS(Ch), .NIBBLES(Nib)) bus ();

  clock_timer_multi dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] fac;
    logic [3:0] msk;
    logic [3:0] dat;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  int unsigned m_cnt;
  int unsigned m_snap;
  logic [3:0]  m_fac;
  logic [3:0]  m_msk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  function automatic logic [3:0] window(input int unsigned v, input int k);
    return 4'((v >> (Lsb + 4 * k)) & 32'd15);
  endfunction

  // Apply one cycle of inputs, queue the expected outputs, then advance the model.
  task automatic step(input logic rn, input logic ce, input logic rr, input logic tr,
                      input logic mwe, input logic [3:0] mwd, input logic fre,
                      input logic dre, input int sel);
    exp_t       e;
    logic [3:0] set;
    reset_n         = rn;
    bus.clk_en      = ce;
    bus.run         = rr;
    bus.timer_reset = tr;
    bus.mask_we     = mwe;
    bus.mask_wdata  = mwd;
    bus.factor_re   = fre;
    bus.data_re     = dre;
    bus.data_sel    = 1'(sel);
    if (!rn) begin
      m_cnt  = 0;
      m_snap = 0;
      m_fac  = '0;
      m_msk  = '0;
    end
    e.cyc = cyc;
    e.fac = m_fac;
    e.msk = m_msk;
    e.irq = |(m_fac & m_msk);
    if (!dre)           e.dat = 4'h0;
    else if (sel == 0)  e.dat = window(m_cnt, 0);
    else if (sel < Nib) e.dat = window(m_snap, sel);
    else                e.dat = 4'h0;
    sb.push_back(e);
    @(posedge clk);
    if (rn) begin
      set = '0;
      if (!tr && ce && rr) begin
        for (int k = 0; k < Ch; k++) begin
          int unsigned period;
          period = 32'd1 << (Taps[k] + 1);
          if (m_cnt % period == period - 1) set[k] = 1'b1;
        end
      end
      if (dre && sel == 0) m_snap = m_cnt;
      if (tr)            m_cnt = 0;
      else if (ce && rr) m_cnt = (m_cnt + 1) % (32'd1 << Cw);
      m_fac = fre ? set : (m_fac | set);
      if (mwe) m_msk = mwd;
    end
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL sb_order got=%0d want=%0d", cyc, e.cyc);
      end
      cmp("factor", bus.factor, e.fac);
      cmp("mask", bus.mask, e.msk);
      cmp("interrupt", {3'b000, bus.interrupt}, {3'b000, e.irq});
      cmp("data_out", bus.data_out, e.dat);
    end
  end

  function automatic logic pct(input int unsigned p);
    return 1'($urandom_range(0, 99) < p);
  endfunction

  initial begin
    // Power-on reset.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hf, 1'b1, 1'b1, 1);

    // Full 1 Hz period at every tick: all four factors set, 32 Hz mask early.
    for (int i = 0; i < 33000; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'((i == 5) || ($urandom_range(0, 2999) == 0)),
           (i == 5) ? 4'b0001 : 4'($urandom_range(0, 15)), 1'b0,
           pct(50), int'($urandom_range(0, 1)));
    end

    // Fully random traffic.
    for (int i = 0; i < 15000; i++) begin
      step(1'b1, pct(70), pct(90), 1'($urandom_range(0, 2999) == 0), pct(1),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 199) == 0),
           pct(50), int'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-count, then a clean run with a timer_reset and a read.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'(i == 1500), 1'(i == 3), 4'b0011, 1'(i == 1100),
           pct(50), int'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_timer_multi.md
CLOCK_TIMER_MULTI -- requirements
Module: clock_timer_multi

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 15, width of the free-running prescaler counter.
REQ-002 SHALL have parameter CHANNELS, default 4, number of interrupt factor/mask channels.
REQ-003 SHALL have parameter TAPS, default {14,13,11,9}, packed counter-bit index per channel (channel 0 = LSB entry = 9).
REQ-004 SHALL have parameter DATA_LSB, default 7, lowest counter bit exposed through data_out.
REQ-005 SHALL have parameter NIBBLES, default 2, number of 4-bit readable counter windows.
REQ-006 SHALL have one clock and asynchronous active-low reset.
REQ-007 SHALL have the following ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  32768 Hz tick, one clk wide
- run  in  1  counter advance enable
- timer_reset  in  1  synchronous counter clear pulse
- mask_we  in  1  mask write strobe
- mask_wdata  in  CHANNELS  mask write data
- mask  out  CHANNELS  interrupt mask register
- factor_re  in  1  factor read strobe (clear-on-read)
- factor  out  CHANNELS  interrupt factor register
- interrupt  out  1  |(factor & mask)
- data_re  in  1  counter window read strobe
- data_sel  in  clog2(NIBBLES)  window index
- data_out  out  4  selected counter window

Function
REQ-008 Counter SHALL increment by 1 on each clk edge with clk_en=1 and run=1, wrapping 2^COUNTER_WIDTH-1 -> 0; otherwise it holds.
REQ-009 Channel i factor bit SHALL set on the clk edge where the counter advances with bits [TAPS[i]:0] all ones (falling edge of tap bit). With defaults: channel 0 = 32 Hz (every 1024 ticks), 1 = 8 Hz (4096), 2 = 2 Hz (16384), 3 = 1 Hz (32768).
REQ-010 Factor bits SHALL be sticky until cleared by factor_re; factor_re SHALL clear all bits on the next edge.
REQ-011 Simultaneous factor_re and set of bit i SHALL leave bit i = 1; all other bits clear.
REQ-012 mask SHALL load mask_wdata on the edge with mask_we=1; otherwise hold.
REQ-013 interrupt SHALL be combinational |(factor & mask) from registered state, with no added latency.
REQ-014 timer_reset SHALL clear the counter on the next edge, override a coincident increment, set no factor that cycle, and leave factor and mask unchanged.
REQ-015 Window k SHALL be counter[DATA_LSB+4k+3 : DATA_LSB+4k].
REQ-016 data_re with data_sel=0 SHALL return the live window 0 combinationally and latch the whole counter into a snapshot on that edge.
REQ-017 data_re with data_sel>0 SHALL return the window from the snapshot, giving a tear-free multi-nibble read.
REQ-018 data_sel >= NIBBLES SHALL return 4'h0.
REQ-019 Elaboration SHALL fail if any TAPS[i] >= COUNTER_WIDTH or DATA_LSB+4*NIBBLES > COUNTER_WIDTH.
REQ-020 With run=0, factors SHALL not set, and factor_re, mask_we and timer_reset SHALL still act.

Reset
REQ-021 While reset_n=0, asynchronously: counter=0, snapshot=0, factor=0, mask=0, interrupt=0, data_out=0.
REQ-022 Assertion mid-count SHALL discard pending sets; the first factor after release SHALL require a full tap period.

Verification
REQ-023 Defaults, run=1, clk_en=1 -> factor: 0001 after 1024 edges, 0011 after 4096, 0111 after 16384, 1111 after 32768 (counter=0).
REQ-024 factor=0011, pulse factor_re -> factor=0000 next edge; repeat on the 32 Hz set edge -> factor=0001.
REQ-025 mask_wdata=0001, mask_we, 1024 ticks -> interrupt=1. mask=0100 with factor=0011 -> interrupt=0 until 16384 ticks, then 1.
REQ-026 Counter=1014, data_sel=0 -> data_out=4'h7. Counter=8182, data_sel=1 -> 4'h3. Counter advancing between the sel0 and sel1 reads -> sel1 returns the snapshot value.
REQ-027 timer_reset at counter=16388 -> counter=0 next edge, factor unchanged; 8 Hz re-sets exactly 4096 ticks later.
REQ-028 reset_n pulsed low at counter=1000 -> all outputs 0 immediately; 32 Hz factor sets 1024 ticks after release.
